// File: rtl/iq_demod_acc.sv
// I/Q demodulator: multiplies each registered ADC sample by +/-1 per the IP/QP
// reference levels and integrates over a programmed number of whole IP periods.
module iq_demod_acc #(
    parameter int DW  = 10,
    parameter int AW  = 24,
    parameter int NPW = 8
) (
    input  logic                 Clk,
    input  logic                 Resetn,
    input  logic                 Start,
    input  logic [NPW-1:0]       NumPeriods,
    input  logic                 SampleValid,
    input  logic [DW-1:0]        Sample,
    input  logic                 IP,
    input  logic                 QP,
    output logic                 Busy,
    output logic                 Done,
    output logic signed [AW-1:0] IAcc,
    output logic signed [AW-1:0] QAcc,
    output logic                 Overflow
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SYNC,
        S_ACC,
        S_DONE
    } state_t;

    localparam logic signed [AW-1:0] ACC_MAX = {1'b0, {(AW-1){1'b1}}};
    localparam logic signed [AW-1:0] ACC_MIN = {1'b1, {(AW-1){1'b0}}};

    state_t                state_q, state_d;
    logic                  ip_r_q, ip_rr_q, qp_r_q, v_r_q;
    logic [DW-1:0]         s_r_q;
    logic signed [AW-1:0]  iacc_q, iacc_d, qacc_q, qacc_d;
    logic                  ovf_q, ovf_d;
    logic [NPW-1:0]        pcnt_q, pcnt_d, np_q, np_d;

    logic                  rise;
    logic                  acc_en;
    logic [NPW-1:0]        pcnt_inc;
    logic signed [AW-1:0]  s_ext, p_i, p_q;
    logic signed [AW:0]    sum_i, sum_q;
    logic                  sat_i, sat_q;
    logic signed [AW-1:0]  iacc_sat, qacc_sat;

    assign rise     = ip_r_q & ~ip_rr_q;
    assign pcnt_inc = pcnt_q + NPW'(1);

    // Widen before negating so that -(most negative sample) stays exact.
    assign s_ext = AW'($signed(s_r_q));
    assign p_i   = ip_r_q ? s_ext : -s_ext;
    assign p_q   = qp_r_q ? s_ext : -s_ext;

    assign sum_i = {iacc_q[AW-1], iacc_q} + {p_i[AW-1], p_i};
    assign sum_q = {qacc_q[AW-1], qacc_q} + {p_q[AW-1], p_q};
    assign sat_i = sum_i[AW] ^ sum_i[AW-1];
    assign sat_q = sum_q[AW] ^ sum_q[AW-1];
    assign iacc_sat = sat_i ? (sum_i[AW] ? ACC_MIN : ACC_MAX) : sum_i[AW-1:0];
    assign qacc_sat = sat_q ? (sum_q[AW] ? ACC_MIN : ACC_MAX) : sum_q[AW-1:0];

    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            ip_r_q  <= 1'b0;
            ip_rr_q <= 1'b0;
            qp_r_q  <= 1'b0;
            v_r_q   <= 1'b0;
            s_r_q   <= '0;
        end else begin
            ip_r_q  <= IP;
            ip_rr_q <= ip_r_q;
            qp_r_q  <= QP;
            v_r_q   <= SampleValid;
            s_r_q   <= Sample;
        end
    end

    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= S_IDLE;
            iacc_q  <= '0;
            qacc_q  <= '0;
            ovf_q   <= 1'b0;
            pcnt_q  <= '0;
            np_q    <= '0;
        end else begin
            state_q <= state_d;
            iacc_q  <= iacc_d;
            qacc_q  <= qacc_d;
            ovf_q   <= ovf_d;
            pcnt_q  <= pcnt_d;
            np_q    <= np_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pcnt_d  = pcnt_q;
        np_d    = np_q;
        acc_en  = 1'b0;
        iacc_d  = iacc_q;
        qacc_d  = qacc_q;
        ovf_d   = ovf_q;

        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    iacc_d  = '0;
                    qacc_d  = '0;
                    ovf_d   = 1'b0;
                    pcnt_d  = '0;
                    np_d    = (NumPeriods == '0) ? NPW'(1) : NumPeriods;
                    state_d = S_SYNC;
                end
            end
            S_SYNC: begin
                if (rise) begin
                    acc_en  = v_r_q;
                    pcnt_d  = '0;
                    state_d = S_ACC;
                end
            end
            S_ACC: begin
                if (rise) begin
                    pcnt_d = pcnt_inc;
                    // The terminating rise sample belongs to the next window.
                    if (pcnt_inc == np_q) begin
                        state_d = S_DONE;
                    end else begin
                        acc_en = v_r_q;
                    end
                end else begin
                    acc_en = v_r_q;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (acc_en) begin
            iacc_d = iacc_sat;
            qacc_d = qacc_sat;
            ovf_d  = ovf_q | sat_i | sat_q;
        end
    end

    assign Busy     = (state_q == S_SYNC) || (state_q == S_ACC);
    assign Done     = (state_q == S_DONE);
    assign IAcc     = iacc_q;
    assign QAcc     = qacc_q;
    assign Overflow = ovf_q;

endmodule

// File: tb/tb_iq_demod_acc.sv
// Directed bench for iq_demod_acc: a default-width instance plus an AW=12
// instance sharing the same stimulus to exercise saturation.
module tb_iq_demod_acc;

    localparam int DW  = 10;
    localparam int NPW = 8;

    logic                 Clk = 1'b0;
    logic                 Resetn = 1'b0;
    logic                 Start = 1'b0;
    logic [NPW-1:0]       NumPeriods = '0;
    logic                 SampleValid = 1'b0;
    logic [DW-1:0]        Sample = '0;
    logic                 IP = 1'b0;
    logic                 QP = 1'b0;

    logic                 Busy, Done, Overflow;
    logic signed [23:0]   IAcc, QAcc;
    logic                 BusyS, DoneS, OverflowS;
    logic signed [11:0]   IAccS, QAccS;

    int checks = 0;
    int errors = 0;

    int period = 32;
    int phase  = 0;
    int mode   = 0;
    bit alt_valid = 1'b0;
    bit vtog = 1'b0;

    iq_demod_acc #(.DW(DW), .AW(24), .NPW(NPW)) u_dut (
        .Clk(Clk), .Resetn(Resetn), .Start(Start), .NumPeriods(NumPeriods),
        .SampleValid(SampleValid), .Sample(Sample), .IP(IP), .QP(QP),
        .Busy(Busy), .Done(Done), .IAcc(IAcc), .QAcc(QAcc), .Overflow(Overflow)
    );

    iq_demod_acc #(.DW(DW), .AW(12), .NPW(NPW)) u_sat (
        .Clk(Clk), .Resetn(Resetn), .Start(Start), .NumPeriods(NumPeriods),
        .SampleValid(SampleValid), .Sample(Sample), .IP(IP), .QP(QP),
        .Busy(BusyS), .Done(DoneS), .IAcc(IAccS), .QAcc(QAccS), .Overflow(OverflowS)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive one cycle of reference/sample stimulus, then step past the next edge.
    task automatic cyc();
        int qph;
        logic ip_v, qp_v;
        logic signed [DW-1:0] s;
        qph  = (phase + period - period / 4) % period;
        ip_v = (phase < period / 2);
        qp_v = (qph < period / 2);
        case (mode)
            0: s = ip_v ? 10'sd100 : -10'sd100;
            1: s = qp_v ? 10'sd100 : -10'sd100;
            2: s = 10'sd100;
            3: s = ip_v ? 10'sd0 : -10'sd512;
            default: s = ip_v ? 10'sd511 : -10'sd511;
        endcase
        IP = ip_v;
        QP = qp_v;
        Sample = s;
        SampleValid = alt_valid ? vtog : 1'b1;
        vtog = ~vtog;
        @(posedge Clk);
        #1;
        phase = (phase + 1) % period;
    endtask

    // Start at phase P/4 (IP already high) so the first rise is at j = 3P/4
    // and Done appears after cycle j = 3P/4 + 1 + P*np.
    task automatic measure(input string tag, input int numper, input int npx, input bit dbl,
                           input int exp_i, input int exp_q);
        int done_cnt;
        int done_j;
        int exp_j;
        logic busy_at_done;
        done_cnt = 0;
        done_j = -1;
        busy_at_done = 1'b1;
        exp_j = 3 * period / 4 + 1 + period * npx;
        phase = period / 4 - 1;
        Start = 1'b0;
        cyc();
        Start = 1'b1;
        NumPeriods = NPW'(numper);
        cyc();
        Start = 1'b0;
        NumPeriods = 8'd7;
        chk({tag, "_busy_after_start"}, Busy, 1);
        chk({tag, "_iacc_cleared"}, IAcc, 0);
        chk({tag, "_sat_iacc_cleared"}, IAccS, 0);
        chk({tag, "_sat_ovf_cleared"}, OverflowS, 0);
        for (int j = 1; j <= exp_j + 4; j++) begin
            Start = (dbl && j == exp_j - 15);
            cyc();
            if (Done) begin
                done_cnt++;
                done_j = j;
                busy_at_done = Busy;
            end
        end
        Start = 1'b0;
        chk({tag, "_done_count"}, done_cnt, 1);
        chk({tag, "_done_cycle"}, done_j, exp_j);
        chk({tag, "_busy_at_done"}, busy_at_done, 0);
        chk({tag, "_iacc"}, IAcc, exp_i);
        chk({tag, "_qacc"}, QAcc, exp_q);
        chk({tag, "_ovf"}, Overflow, 0);
    endtask

    initial begin
        int dn;
        Resetn = 1'b0;
        mode = 0;
        repeat (3) cyc();
        chk("rst_busy", Busy, 0);
        chk("rst_done", Done, 0);
        chk("rst_iacc", IAcc, 0);
        chk("rst_qacc", QAcc, 0);
        chk("rst_ovf", Overflow, 0);
        Resetn = 1'b1;
        repeat (2) cyc();

        period = 32;
        mode = 0; measure("inphase", 1, 1, 1'b0, 3200, 0);
        mode = 1; measure("quad", 4, 4, 1'b0, 0, 12800);
        mode = 2; measure("dc", 1, 1, 1'b0, 0, 0);
        mode = 0; measure("np_zero", 0, 1, 1'b0, 3200, 0);
        mode = 3; measure("neg_full", 2, 2, 1'b0, 16384, 0);

        period = 16;
        mode = 0; measure("period16", 3, 3, 1'b0, 4800, 0);

        period = 32;
        mode = 4; measure("big_511", 2, 2, 1'b0, 32704, 0);
        chk("sat_iacc", IAccS, 2047);
        chk("sat_ovf", OverflowS, 1);

        mode = 0; measure("dbl_start", 1, 1, 1'b1, 3200, 0);

        alt_valid = 1'b1;
        measure("alt_valid", 1, 1, 1'b0, 1600, 0);
        alt_valid = 1'b0;

        // Reset in the middle of the accumulation phase.
        mode = 0;
        phase = period / 4 - 1;
        cyc();
        Start = 1'b1;
        NumPeriods = 8'd1;
        cyc();
        Start = 1'b0;
        for (int j = 1; j <= 39; j++) cyc();
        chk("mid_iacc_before_rst", IAcc, 1500);
        chk("mid_busy_before_rst", Busy, 1);
        Resetn = 1'b0;
        #2;
        chk("mid_rst_busy", Busy, 0);
        chk("mid_rst_iacc", IAcc, 0);
        chk("mid_rst_qacc", QAcc, 0);
        dn = 0;
        for (int j = 0; j < 4; j++) begin
            cyc();
            if (Done) dn++;
        end
        Resetn = 1'b1;
        for (int j = 0; j < 40; j++) begin
            cyc();
            if (Done) dn++;
        end
        chk("mid_rst_no_done", dn, 0);
        measure("after_rst", 1, 1, 1'b0, 3200, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/iq_demod_acc.md
# iq_demod_acc

Synchronous I/Q demodulator and accumulator for the impedance-measurement receive path. It consumes signed ADC samples of the response to the stepped DAC sinusoid. Each sample is multiplied by ±1 according to the I and Q reference clocks (IP, QP) that the DAC controller generates. The products are accumulated over a programmed whole number of excitation periods, yielding the in-phase and quadrature components of the measured signal.

## Interface
Parameters:
- DW, 10, sample width, signed two's complement
- AW, 24, accumulator width, signed; AW > DW required
- NPW, 8, width of period-count field

Ports:
- Clk  in  1  system clock; same clock as the DAC controller
- Resetn  in  1  asynchronous, active-low reset
- Start  in  1  single-cycle pulse; clears accumulators and arms a measurement
- NumPeriods  in  NPW  number of full IP periods to integrate; 0 treated as 1
- SampleValid  in  1  Sample qualifier
- Sample  in  DW  signed ADC sample
- IP  in  1  in-phase reference clock, level, Clk-synchronous
- QP  in  1  quadrature reference clock, level
- Busy  out  1  high from accepted Start until Done
- Done  out  1  one-cycle pulse; results final
- IAcc  out  AW  signed in-phase accumulator
- QAcc  out  AW  signed quadrature accumulator
- Overflow  out  1  sticky; set if either accumulator saturated this measurement

## Operation
- Input stage: IP, QP, Sample and SampleValid are registered once (ip_r, qp_r, s_r, v_r). ip_rr is a second IP stage. Rise = ip_r & ~ip_rr.
- Products: pI = ip_r ? +s_r : −s_r; pQ = qp_r ? +s_r : −s_r. Operands are sign-extended to AW before negation; −(−2^(DW−1)) is exact.
- Accumulate: acc + p, saturating to [−2^(AW−1), 2^(AW−1)−1]. Any saturation sets Overflow, which stays set until the next accepted Start.
- FSM states: IDLE, SYNC, ACC, DONE.
  - IDLE: Busy=0. On Start, clear IAcc, QAcc, Overflow and the period counter pcnt, latch NumPeriods (0→1) into np, then go to SYNC.
  - SYNC: wait for Rise. On the Rise cycle, accumulate that cycle's sample if v_r, set pcnt=0, and go to ACC.
  - ACC: accumulate every cycle with v_r=1. On Rise, pcnt←pcnt+1. If pcnt+1 == np, go to DONE and do not accumulate that cycle's sample. Otherwise accumulate it.
  - DONE: Done=1 for one cycle, Busy=0 in that cycle, then go to IDLE.
- IAcc, QAcc and Overflow hold their final values in IDLE until the next accepted Start.
- Start is ignored in SYNC, ACC and DONE.
- NumPeriods changes after Start have no effect on the current measurement.
- IP stuck constant: the block stays in SYNC or ACC indefinitely. No timeout.

## Timing
- Reset values: state IDLE; Busy=0, Done=0, IAcc=0, QAcc=0, Overflow=0; pcnt=0, np=0, all input registers 0.
- Busy rises the cycle after Start.
- Pipeline: an input edge on IP at cycle t yields Rise at t+2, because ip_r updates at t+1. Sample at t is aligned with ip_r at t+1 and enters the accumulator at t+2.
- Integration window: exactly np×T sample cycles, where T is the IP period in Clk cycles (32 or 16 with the DAC controller). The window starts at the first sampled IP-high cycle after arming.
- Done is asserted on the cycle after the terminating Rise is detected. IAcc and QAcc are stable from that cycle.
- Reset mid-measurement: immediate return to IDLE, outputs zeroed, with no Done.

## Test plan
- In-phase square wave: period 32, IP high 16 cycles, QP lagging IP by 8 cycles. Sample = +100 while IP high, −100 while low, SampleValid=1, NumPeriods=1 → Done once, IAcc=3200, QAcc=0, Overflow=0.
- Quadrature and DC: Sample = +100 while QP high, −100 otherwise, NumPeriods=4 → IAcc=0, QAcc=12800. Separately, constant Sample=+100 → IAcc=0, QAcc=0.
- Edge cases: NumPeriods=0 behaves identically to 1, integrating 32 samples. Sample=−512 with DW=10 and in-phase drive → IAcc=16384, no overflow. Period 16 with NumPeriods=3 → 48 samples integrated.
- Saturation with AW=12: Sample=+511 in phase, NumPeriods=2 → IAcc=2047 and Overflow=1. A following Start clears Overflow and both accumulators to 0.
- Protocol: a second Start during ACC is ignored, with Done occurring exactly once at the original schedule. SampleValid low on alternate cycles → results halved, IAcc=1600 for the first scenario.
- Reset: Resetn asserted mid-ACC → Busy=0, IAcc=QAcc=0, no Done pulse. After release, a new Start completes normally.
